// File: rtl/memory_array_pkg.sv
// ============================================================================
// memory_array_pkg : shared state encoding and default parameters | rev 1.0
// ============================================================================
`default_nettype none

package memory_array_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } state_t;

  localparam int DEF_DATA_W            = 8;
  localparam int DEF_ADDR_W            = 3;
  localparam int DEF_SLEEP_IDLE_CYCLES = 10;
  localparam int DEF_WAKE_CYCLES       = 2;

  // A counter that must reach max_val; a zero maximum still gets one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_array_if.sv
// ============================================================================
// memory_array_if : request/response bus of the memory array controller | rev 1.0
// ============================================================================
`default_nettype none

interface memory_array_if
  import memory_array_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sleep;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, sleep, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, sleep, busy
  );

endinterface

`default_nettype wire

// File: rtl/memory_array_core.sv
// ============================================================================
// memory_array_core : single-port storage, sync write, registered read | rev 1.0
// ============================================================================
`default_nettype none

module memory_array_core
  import memory_array_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset clears every word, so the array is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      if (re) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_array_ctrl.sv
// ============================================================================
// memory_array_ctrl : memory array with handshake, idle sleep and counted wake | rev 1.0
// ============================================================================
`default_nettype none

module memory_array_ctrl
  import memory_array_pkg::*;
#(
  parameter int DATA_W            = DEF_DATA_W,
  parameter int ADDR_W            = DEF_ADDR_W,
  parameter int SLEEP_IDLE_CYCLES = DEF_SLEEP_IDLE_CYCLES,
  parameter int WAKE_CYCLES       = DEF_WAKE_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  memory_array_if.slave  bus
);

  localparam int IDLE_W = cnt_width(SLEEP_IDLE_CYCLES);
  localparam int WAKE_W = cnt_width(WAKE_CYCLES);

  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SLEEP_IDLE_CYCLES);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_nxt;
  logic [WAKE_W-1:0] wake_cnt;
  logic [WAKE_W-1:0] wake_nxt;
  logic              accept;
  logic              idle_hit;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata;

  // Requests are only ever taken while ACTIVE; ready is a pure state decode.
  assign accept = bus.req_valid && (state == ACTIVE);

  generate
    if (SLEEP_IDLE_CYCLES > 0) begin : g_sleep_en
      localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SLEEP_IDLE_CYCLES - 1);
      assign idle_hit = (idle_cnt == IDLE_LAST);
    end else begin : g_sleep_dis
      assign idle_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACTIVE;
      idle_cnt    <= '0;
      wake_cnt    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      idle_cnt    <= idle_nxt;
      wake_cnt    <= wake_nxt;
      rsp_valid_q <= accept && !bus.req_we;
    end
  end

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    wake_nxt  = wake_cnt;
    case (state)
      ACTIVE: begin
        if (accept) begin
          idle_nxt = '0;
        end else begin
          if (idle_cnt != IDLE_MAX) begin
            idle_nxt = idle_cnt + 1'b1;
          end
          // idle_hit means this is the last permitted idle cycle.
          if (idle_hit) begin
            state_nxt = SLEEP;
          end
        end
      end
      SLEEP: begin
        if (bus.req_valid) begin
          state_nxt = WAKE;
          wake_nxt  = '0;
        end
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_nxt = ACTIVE;
          idle_nxt  = '0;
          wake_nxt  = '0;
        end else begin
          wake_nxt = wake_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ACTIVE;
        idle_nxt  = '0;
        wake_nxt  = '0;
      end
    endcase
  end

  memory_array_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && bus.req_we),
    .re    (accept && !bus.req_we),
    .addr  (bus.req_addr),
    .wdata (bus.req_wdata),
    .rdata (rdata)
  );

  assign bus.req_ready = (state == ACTIVE);
  assign bus.sleep     = (state == SLEEP);
  assign bus.busy      = (state == WAKE) || rsp_valid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata;

endmodule

`default_nettype wire

// File: tb/tb_memory_array_ctrl.sv
// ============================================================================
// tb_memory_array_ctrl : scoreboard bench for default and wide/no-sleep configs | rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_array_ctrl;

  typedef struct {
    int data;
    int due;
  } exp_t;

  localparam int NIDLE [2] = '{10, 0};
  localparam int NWAKE     = 2;
  localparam int DMASK [2] = '{'hFF, 'hFFFF};
  localparam int DEPTH [2] = '{8, 32};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic d_valid [2];
  logic d_we    [2];
  int   d_addr  [2];
  int   d_wdata [2];

  memory_array_if #(.DATA_W(8),  .ADDR_W(3)) a_if ();
  memory_array_if #(.DATA_W(16), .ADDR_W(5)) b_if ();

  assign a_if.req_valid = d_valid[0];
  assign a_if.req_we    = d_we[0];
  assign a_if.req_addr  = 3'(d_addr[0]);
  assign a_if.req_wdata = 8'(d_wdata[0]);
  assign b_if.req_valid = d_valid[1];
  assign b_if.req_we    = d_we[1];
  assign b_if.req_addr  = 5'(d_addr[1]);
  assign b_if.req_wdata = 16'(d_wdata[1]);

  memory_array_ctrl #(
    .DATA_W(8), .ADDR_W(3), .SLEEP_IDLE_CYCLES(10), .WAKE_CYCLES(NWAKE)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  memory_array_ctrl #(
    .DATA_W(16), .ADDR_W(5), .SLEEP_IDLE_CYCLES(0), .WAKE_CYCLES(NWAKE)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // Reference model: mode 0 = active, 1 = sleeping, 2 = waking; timing kept as edge numbers.
  int   cyc = 0;
  int   mode     [2];
  int   act_ref  [2];
  int   wake_w   [2];
  bit   last_acc [2];
  bit   rsp_due  [2];
  int   mem_m    [2][32];
  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input int i);
    exp_t e;
    last_acc[i] = 1'b0;
    rsp_due[i]  = 1'b0;
    if (rst) begin
      mode[i]    = 0;
      act_ref[i] = cyc;
      for (int a = 0; a < 32; a++) mem_m[i][a] = 0;
      if (i == 0) qa.delete(); else qb.delete();
      return;
    end
    case (mode[i])
      0: begin
        if (d_valid[i]) begin
          last_acc[i] = 1'b1;
          act_ref[i]  = cyc;
          if (d_we[i]) begin
            mem_m[i][d_addr[i]] = d_wdata[i] & DMASK[i];
          end else begin
            e.data = mem_m[i][d_addr[i]];
            e.due  = cyc;
            rsp_due[i] = 1'b1;
            if (i == 0) qa.push_back(e); else qb.push_back(e);
          end
        end
        if (NIDLE[i] > 0 && cyc - act_ref[i] >= NIDLE[i]) mode[i] = 1;
      end
      1: begin
        if (d_valid[i]) begin
          mode[i]   = 2;
          wake_w[i] = cyc;
        end
      end
      default: begin
        if (cyc - wake_w[i] >= NWAKE) begin
          mode[i]    = 0;
          act_ref[i] = cyc;
        end
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; act_ref[i] = 0; wake_w[i] = 0; last_acc[i] = 0; rsp_due[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  task automatic monitor(input int i);
    logic rv, rdy, slp, bsy;
    int   rd;
    bit   exp_rv;
    exp_t e;
    if (i == 0) begin
      rv = a_if.rsp_valid; rd = 32'(a_if.rsp_rdata);
      rdy = a_if.req_ready; slp = a_if.sleep; bsy = a_if.busy;
      exp_rv = (qa.size() > 0) && (qa[0].due == cyc);
      if (exp_rv) e = qa[0];
    end else begin
      rv = b_if.rsp_valid; rd = 32'(b_if.rsp_rdata);
      rdy = b_if.req_ready; slp = b_if.sleep; bsy = b_if.busy;
      exp_rv = (qb.size() > 0) && (qb[0].due == cyc);
      if (exp_rv) e = qb[0];
    end
    chk($sformatf("req_ready[%0d]", i), 32'(rdy), 32'(mode[i] == 0));
    chk($sformatf("sleep[%0d]", i),     32'(slp), 32'(mode[i] == 1));
    chk($sformatf("busy[%0d]", i),      32'(bsy), 32'(mode[i] == 2 || rsp_due[i]));
    chk($sformatf("rsp_valid[%0d]", i), 32'(rv),  32'(exp_rv));
    if (rv && exp_rv) chk($sformatf("rsp_rdata[%0d]", i), rd, e.data);
    if (i == 0) begin
      while (qa.size() > 0 && qa[0].due <= cyc) void'(qa.pop_front());
    end else begin
      while (qb.size() > 0 && qb[0].due <= cyc) void'(qb.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) monitor(i);
    end
  end

  // Present a request and hold it until the model reports the accept edge.
  task automatic send(input int i, input bit we, input int addr, input int data,
                      output int acc_edge);
    d_we[i] = we; d_addr[i] = addr; d_wdata[i] = data; d_valid[i] = 1'b1;
    acc_edge = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (last_acc[i]) begin
        acc_edge = cyc;
        break;
      end
    end
    if (acc_edge < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout[%0d]: no accept within 100 cycles", i);
      d_valid[i] = 1'b0;
    end
  endtask

  task automatic idle(input int i, input int n);
    d_valid[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int karl [8];
    int e, first, last, k, s;
    karl = '{'h4B, 'h61, 'h72, 'h6C, 'h21, 'h21, 'h21, 'h21};
    for (int i = 0; i < 2; i++) begin
      d_valid[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 0; d_wdata[i] = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_rsp_rdata_a", 32'(a_if.rsp_rdata), 0);
    chk("reset_rsp_rdata_b", 32'(b_if.rsp_rdata), 0);
    rst = 1'b0;

    // Back-to-back writes then reads of the whole default array.
    for (int a = 0; a < 8; a++) send(0, 1'b1, a, karl[a], e);
    for (int a = 0; a < 8; a++) begin
      send(0, 1'b0, a, 0, e);
      if (a == 0) first = e;
      last = e;
    end
    chk("karl_read_span", last - first, 7);

    send(0, 1'b1, 3, 'hA5, e);
    send(0, 1'b0, 3, 0, e);
    k = e;

    // Idle into sleep, measured from the last accept.
    d_valid[0] = 1'b0;
    s = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (a_if.sleep) begin
        s = cyc;
        break;
      end
    end
    chk("sleep_entry_delay", s - k, 10);

    // Wake with a read of address 2 while sleeping.
    s = cyc;
    send(0, 1'b0, 2, 0, e);
    chk("wake_accept_delay", e - s, NWAKE + 2);
    for (int a = 0; a < 8; a++) send(0, 1'b0, a, 0, e);

    // An accept in the threshold idle cycle keeps the array active.
    send(0, 1'b1, 5, 'h3C, k);
    idle(0, 9);
    send(0, 1'b1, 6, 'hC3, e);
    chk("threshold_accept", e - k, 10);
    idle(0, 5);
    chk("threshold_still_active", 32'(a_if.sleep), 0);

    // Reset while waking.
    idle(0, 8);
    chk("sleep_before_wake_reset", 32'(a_if.sleep), 1);
    d_we[0] = 1'b0; d_addr[0] = 1; d_valid[0] = 1'b1;
    @(negedge clk);
    chk("busy_in_wake", 32'(a_if.busy), 1);
    rst = 1'b1; d_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("ready_after_wake_reset", 32'(a_if.req_ready), 1);

    // Reset coinciding with a read request.
    send(0, 1'b1, 4, 'h99, e);
    d_we[0] = 1'b0; d_addr[0] = 4; d_valid[0] = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_valid[0] = 1'b0;
    chk("rst_rsp_suppressed", 32'(a_if.rsp_valid), 0);
    for (int a = 0; a < 8; a++) send(0, 1'b0, a, 0, e);
    idle(0, 1);

    // Random traffic on the wide configuration with sleep disabled.
    for (int n = 0; n < 400; n++) begin
      send(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH[1] - 1)),
           int'($urandom & 32'hFFFF), e);
      if ($urandom_range(0, 7) == 0) idle(1, int'($urandom_range(1, 3)));
    end
    idle(1, 3);
    chk("no_sleep_wide", 32'(b_if.sleep), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
